// File: rtl/string_packer_if.sv
// Character-in / string-out bundle between a character source, the packer and a string consumer.
// Latency: none, wires only.
// Backpressure: char_ready and out_ready are carried here; the packer drives the slave side.
interface string_packer_if #(
  parameter int CHAR_W    = 8,
  parameter int NUM_CHARS = 8,
  parameter int LEN_W     = 4
);
  logic [CHAR_W-1:0]           char_in;
  logic                        char_valid;
  logic                        char_ready;
  logic                        abort;
  logic [NUM_CHARS*CHAR_W-1:0] string_out;
  logic [LEN_W-1:0]            length_out;
  logic                        out_valid;
  logic                        out_ready;

  // Character source and string consumer side.
  modport master (
    output char_in, char_valid, abort, out_ready,
    input  char_ready, string_out, length_out, out_valid
  );

  // Packer side.
  modport slave (
    input  char_in, char_valid, abort, out_ready,
    output char_ready, string_out, length_out, out_valid
  );
endinterface

// File: rtl/string_packer.sv
// Packs a valid/ready character stream into a zero-padded NUL-terminated string plus its length.
// Latency: out_valid rises the cycle after the terminating accept (NUL or last free byte).
// Backpressure: char_ready is low while a finished string waits; a new character is taken one cycle after the string leaves.
module string_packer #(
  parameter int CHAR_W    = 8,
  parameter int NUM_CHARS = 8,
  parameter int LEN_W     = 4
) (
  input logic           clk,
  input logic           rst_n,
  string_packer_if.slave bus
);
  localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t                           state;
  logic [NUM_CHARS-1:0][CHAR_W-1:0] buf_q;
  logic [LEN_W-1:0]                 count;
  logic [IDX_W-1:0]                 wr_idx;

  // count only reaches NUM_CHARS in DONE, where no write happens, so the low bits index safely.
  assign wr_idx = count[IDX_W-1:0];

  // Collect characters, close on NUL or full buffer, hold until the consumer takes the string.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      count <= '0;
      buf_q <= '0;
    end else if (bus.abort) begin
      // Flush wins over any accept or output handshake in the same cycle.
      state <= COLLECT;
      count <= '0;
      buf_q <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.char_valid) begin
            if (bus.char_in == '0) begin
              // NUL terminates without being stored; bytes above count stay zero.
              state <= DONE;
            end else begin
              buf_q[wr_idx] <= bus.char_in;
              count         <= count + LEN_W'(1);
              if (count == LEN_W'(NUM_CHARS - 1)) begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= COLLECT;
            count <= '0;
            buf_q <= '0;
          end
        end
        default: begin
          state <= COLLECT;
          count <= '0;
          buf_q <= '0;
        end
      endcase
    end
  end

  assign bus.char_ready = (state == COLLECT);
  assign bus.out_valid  = (state == DONE);
  assign bus.string_out = buf_q;
  assign bus.length_out = count;
endmodule
